// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: state encodings, opcodes and control-field codes shared by the multi-cycle controller.
package mc_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        I_EXEC   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        JAL      = 4'd12
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_LB   = 6'h20;
    localparam logic [5:0] OP_SB   = 6'h28;

    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] ALU_FUNCT   = 2'b10;
    localparam logic [1:0] ALU_IMM     = 2'b11;
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PCS_ALU     = 2'b00;
    localparam logic [1:0] PCS_ALUOUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP    = 2'b10;
    localparam logic [1:0] RDST_RT     = 2'b00;
    localparam logic [1:0] RDST_RD     = 2'b01;
    localparam logic [1:0] RDST_RA     = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       mem_byte;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctl_t;

    function automatic logic is_load(logic [5:0] op);
        return op == OP_LW || op == OP_LB;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: controller <-> datapath/memory bundle; master = controller, slave = datapath side.
interface mc_ctrl_fsm_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       mem_byte;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_err;
    logic [3:0] state;

    modport master (
        input  op, mem_ready,
        output mem_req, mem_read, mem_write, mem_byte, i_or_d, ir_write, pc_write, pc_write_cond,
               branch_ne, pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               mem_err, state
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, mem_read, mem_write, mem_byte, i_or_d, ir_write, pc_write, pc_write_cond,
               branch_ne, pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               mem_err, state
    );
endinterface

// File: rtl/mc_ctrl_wait_timer.sv
// mc_ctrl_wait_timer: counts stalled memory-request cycles; flags timeout and pulses mem_err the cycle after.
module mc_ctrl_wait_timer #(
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic ready_i,
    output logic timeout_o,
    output logic mem_err_o
);
    localparam int CW = WAIT_MAX > 1 ? $clog2(WAIT_MAX) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;
    logic          stall;

    assign stall     = req_i && !ready_i;
    assign timeout_o = (WAIT_MAX != 0) && stall && cnt_q == CW'(WAIT_MAX - 1);
    // Any cycle that is not a continuing stall (ready, idle, or the abort itself) restarts the count.
    assign cnt_d     = (stall && !timeout_o) ? cnt_q + 1'b1 : '0;
    assign mem_err_o = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= timeout_o;
        end
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle IF/ID/EX/MEM/WB controller with memory req/ready handshake and wait timeout.
// Optional MC_CTRL_PERF_EN adds cycle and retired-instruction counters.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int WAIT_MAX = 255
`ifdef MC_CTRL_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic clk,
    input  logic rst_n,
    mc_ctrl_fsm_if.master bus
`ifdef MC_CTRL_PERF_EN
    , output logic [PERF_W-1:0] cyc_cnt_o
    , output logic [PERF_W-1:0] ins_cnt_o
`endif
);
    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       timeout;
    logic       mem_err;
    ctl_t       c;

    mc_ctrl_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (bus.mem_req),
        .ready_i   (bus.mem_ready),
        .timeout_o (timeout),
        .mem_err_o (mem_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        c       = '0;
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            FETCH: begin
                c.mem_req   = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_4;
                c.ir_write  = bus.mem_ready;
                c.pc_write  = bus.mem_ready;
                state_d     = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                op_d        = bus.op;
                c.alu_src_b = SRCB_IMM_SH;
                state_d     = bus.op == OP_R   ? R_EXEC :
                              bus.op == OP_J   ? JUMP   :
                              bus.op == OP_JAL ? JAL    :
                              (bus.op == OP_BEQ || bus.op == OP_BNE) ? BRANCH :
                              (is_load(bus.op) || bus.op == OP_SW || bus.op == OP_SB) ? MEM_ADDR : I_EXEC;
            end
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                state_d     = is_load(op_q) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                c.mem_req  = 1'b1;
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
                c.mem_byte = op_q == OP_LB;
                state_d    = bus.mem_ready ? MEM_WB : timeout ? FETCH : MEM_RD;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_dst    = RDST_RT;
                state_d      = FETCH;
            end
            MEM_WR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
                c.mem_byte  = op_q == OP_SB;
                state_d     = (bus.mem_ready || timeout) ? FETCH : MEM_WR;
            end
            R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALU_FUNCT;
                state_d     = R_WB;
            end
            R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = RDST_RD;
                state_d     = FETCH;
            end
            I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_IMM;
                state_d     = I_WB;
            end
            I_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = RDST_RT;
                state_d     = FETCH;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_B;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCS_ALUOUT;
                c.branch_ne     = op_q == OP_BNE;
                state_d         = FETCH;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JUMP;
                state_d     = FETCH;
            end
            JAL: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JUMP;
                c.reg_write = 1'b1;
                c.reg_dst   = RDST_RA;
                state_d     = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Strobes are forced low for as long as reset is held, not just from the next edge.
    assign {bus.mem_req, bus.mem_read, bus.mem_write, bus.mem_byte, bus.i_or_d, bus.ir_write,
            bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.pc_source, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.reg_dst, bus.mem_to_reg, bus.reg_write} = rst_n ? c : '0;
    assign bus.state   = state_q;
    assign bus.mem_err = mem_err;

`ifdef MC_CTRL_PERF_EN
    logic [PERF_W-1:0] cyc_q, ins_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            if (state_d == FETCH && state_q != FETCH && !timeout) ins_q <= ins_q + 1'b1;
        end
    end

    assign cyc_cnt_o = cyc_q;
    assign ins_cnt_o = ins_q;
`endif
endmodule
